// File: rtl/parallel_serial_lanes_if.sv
// Word-side and beat-side ready/valid bundle for parallel_serial_lanes.
// A transfer happens on a rising clock edge where valid and ready are both high.
// valid never waits on ready, and a presented item stays stable until it is taken.
interface parallel_serial_lanes_if #(
  parameter int WORD_WIDTH = 8,
  parameter int LANE_WIDTH = 1
);
  logic                  parallel_in_valid;
  logic                  parallel_in_ready;
  logic [WORD_WIDTH-1:0] parallel_in;
  logic                  serial_out_valid;
  logic                  serial_out_ready;
  logic [LANE_WIDTH-1:0] serial_out;
  logic                  serial_out_last;

  modport master (
    output parallel_in_valid, parallel_in, serial_out_ready,
    input  parallel_in_ready, serial_out_valid, serial_out, serial_out_last
  );

  modport slave (
    input  parallel_in_valid, parallel_in, serial_out_ready,
    output parallel_in_ready, serial_out_valid, serial_out, serial_out_last
  );
endinterface

// File: rtl/parallel_serial_lanes.sv
// Parallel-to-serial converter: loads a word and emits WORD_WIDTH/LANE_WIDTH beats
// in MSB- or LSB-lane-first order, flags the final beat and accepts back-pressure.
module parallel_serial_lanes #(
  parameter int WORD_WIDTH = 8,
  parameter int LANE_WIDTH = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clock,
  input  logic                  clear,
  parallel_serial_lanes_if.slave bus,
  output logic                  dbg_busy_o
);
  localparam int LANE_DIV = (LANE_WIDTH < 1) ? 1 : LANE_WIDTH;
  localparam int BEATS    = WORD_WIDTH / LANE_DIV;
  localparam int CW       = $clog2(BEATS + 1);

  if (WORD_WIDTH < 1 || LANE_WIDTH < 1 || (WORD_WIDTH % LANE_DIV) != 0) begin : g_bad_params
    $error("parallel_serial_lanes: LANE_WIDTH must be >= 1 and divide WORD_WIDTH >= 1");
  end

  typedef enum logic {EMPTY = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [WORD_WIDTH-1:0] shifted;
  logic                  in_hs, out_hs, last;

  // The output lane always sits at one end; shifting moves the next lane into it.
  if (MSB_FIRST) begin : g_msb
    assign bus.serial_out = shift_q[WORD_WIDTH-1 -: LANE_WIDTH];
    assign shifted        = shift_q << LANE_WIDTH;
  end else begin : g_lsb
    assign bus.serial_out = shift_q[LANE_WIDTH-1:0];
    assign shifted        = shift_q >> LANE_WIDTH;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= EMPTY;
      count_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shift_d = shift_q;
    last    = (state_q == BUSY) && (count_q == CW'(1));
    // Ready comes straight from serial_out_ready on the last beat so reloads are gap-free.
    bus.parallel_in_ready = (state_q == EMPTY) || (last && bus.serial_out_ready);
    bus.serial_out_valid  = (state_q == BUSY);
    bus.serial_out_last   = last;
    in_hs  = bus.parallel_in_valid && bus.parallel_in_ready;
    out_hs = bus.serial_out_valid && bus.serial_out_ready;
    if (in_hs) begin
      shift_d = bus.parallel_in;
      count_d = CW'(BEATS);
    end else if (out_hs) begin
      shift_d = shifted;
      count_d = count_q - CW'(1);
    end
    state_d = (count_d == '0) ? EMPTY : BUSY;
  end

  assign dbg_busy_o = (state_q == BUSY);
endmodule
